// File: rtl/ps2_key_receiver_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ps2_key_receiver_if
// Brief    : PS/2 pin inputs and decoded scan-code / arrow-key outputs.
// Revision : 1.0
// ============================================================================
interface ps2_key_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       scan_break;
    logic       scan_ext;
    logic       frame_err;
    logic [3:0] keys;

    modport master (
        output ps2_clk, ps2_data,
        input  scan_code, scan_valid, scan_break, scan_ext, frame_err, keys
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output scan_code, scan_valid, scan_break, scan_ext, frame_err, keys
    );
endinterface
`default_nettype wire

// File: rtl/ps2_key_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ps2_key_receiver
// Brief    : PS/2 keyboard frame receiver with make/break/E0 decode and
//            held arrow-key levels {left, right, up, down}.
// Revision : 1.0
// ============================================================================
module ps2_key_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  wire logic         clk,
    input  wire logic         reset,
    ps2_key_receiver_if.slave bus
);
    localparam int c_FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int c_TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_clk_sync, r_dat_sync;
    logic                r_fclk, r_fclk_d;
    logic [c_FCNT_W-1:0] r_fcnt;
    logic [c_TCNT_W-1:0] r_tcnt;
    logic [2:0]          r_bitcnt;
    logic [7:0]          r_shift;
    logic                r_parity_ok;
    logic                r_ext_pend, r_brk_pend;
    logic [7:0]          r_scan_code;
    logic                r_scan_valid, r_scan_break, r_scan_ext, r_frame_err;
    logic [3:0]          r_keys;

    logic w_sample, w_bit, w_timeout, w_done, w_bad;

    assign w_sample = r_fclk_d & ~r_fclk;
    assign w_bit    = r_dat_sync[1];

    // Synchronizers and glitch filter; everything idles high out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_fclk     <= 1'b1;
            r_fclk_d   <= 1'b1;
            r_fcnt     <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], bus.ps2_clk};
            r_dat_sync <= {r_dat_sync[0], bus.ps2_data};
            r_fclk_d   <= r_fclk;
            if (r_clk_sync[1] == r_fclk) begin
                r_fcnt <= '0;
            end else if (r_fcnt == c_FCNT_W'(FILTER_LEN - 1)) begin
                r_fclk <= r_clk_sync[1];
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + c_FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // A sample event on the terminal count takes priority over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_bad       = 1'b0;
        w_timeout   = (r_state != S_IDLE) && !w_sample &&
                      (r_tcnt == c_TCNT_W'(TIMEOUT_CYCLES - 1));
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end else if (w_sample) begin
            case (r_state)
                S_IDLE:   if (!w_bit) w_state_nxt = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (w_bit && r_parity_ok) w_done = 1'b1;
                    else                      w_bad  = 1'b1;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt      <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_parity_ok <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_sample) r_tcnt <= '0;
            else                               r_tcnt <= r_tcnt + c_TCNT_W'(1);
            if (w_sample) begin
                if (r_state == S_IDLE && !w_bit) r_bitcnt <= '0;
                if (r_state == S_DATA) begin
                    r_shift  <= {w_bit, r_shift[7:1]};
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
                if (r_state == S_PARITY) r_parity_ok <= ^{r_shift, w_bit};
            end
        end
    end

    // Byte decode: prefixes only arm pending flags; other bytes strobe out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
            r_scan_code  <= '0;
            r_scan_valid <= 1'b0;
            r_scan_break <= 1'b0;
            r_scan_ext   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_keys       <= '0;
        end else begin
            r_scan_valid <= 1'b0;
            r_frame_err  <= w_timeout | w_bad;
            if (w_timeout || w_bad) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else if (w_done) begin
                if (r_shift == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_scan_code  <= r_shift;
                    r_scan_break <= r_brk_pend;
                    r_scan_ext   <= r_ext_pend;
                    r_scan_valid <= 1'b1;
                    r_ext_pend   <= 1'b0;
                    r_brk_pend   <= 1'b0;
                    if (r_ext_pend) begin
                        case (r_shift)
                            8'h6B:   r_keys[3] <= ~r_brk_pend;
                            8'h74:   r_keys[2] <= ~r_brk_pend;
                            8'h75:   r_keys[1] <= ~r_brk_pend;
                            8'h72:   r_keys[0] <= ~r_brk_pend;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign bus.scan_code  = r_scan_code;
    assign bus.scan_valid = r_scan_valid;
    assign bus.scan_break = r_scan_break;
    assign bus.scan_ext   = r_scan_ext;
    assign bus.frame_err  = r_frame_err;
    assign bus.keys       = r_keys;
endmodule
`default_nettype wire

// File: tb/tb_ps2_key_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ps2_key_receiver
// Brief    : Directed + randomized PS/2 frames checked against a byte-level model.
// Revision : 1.0
// ============================================================================
module tb_ps2_key_receiver;
    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int BIT_HALF       = 20;
    localparam int LAT_MIN        = 2;
    localparam int LAT_MAX        = FILTER_LEN + 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ps2_key_receiver_if bus();

    ps2_key_receiver #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [7:0]  code;
        logic        brk;
        logic        ext;
        logic [3:0]  keys;
        int unsigned t;
    } ev_t;

    int unsigned cyc = 0;
    int unsigned last_fall = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    ev_t         got_q[$], exp_q[$];
    int unsigned gerr_q[$], eerr_q[$];

    logic        m_ext, m_brk;
    logic [3:0]  m_keys;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.scan_valid)
                got_q.push_back('{bus.scan_code, bus.scan_break, bus.scan_ext, bus.keys, cyc});
            if (bus.frame_err) gerr_q.push_back(cyc);
        end
    end

    // Reference model: one call per received frame, at the level of whole bytes.
    function automatic void model_byte(input logic [7:0] b, input bit ok, input int unsigned t);
        if (!ok) begin
            eerr_q.push_back(t);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (m_ext) begin
                if (b == 8'h6B) m_keys[3] = !m_brk;
                if (b == 8'h74) m_keys[2] = !m_brk;
                if (b == 8'h75) m_keys[1] = !m_brk;
                if (b == 8'h72) m_keys[0] = !m_brk;
            end
            exp_q.push_back('{b, m_brk, m_ext, m_keys, t});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b, input bit glitch);
        @(negedge clk);
        bus.ps2_data = b;
        idle(BIT_HALF / 2 - 1);
        bus.ps2_clk = 1'b0;
        last_fall   = cyc;
        idle(BIT_HALF);
        bus.ps2_clk = 1'b1;
        if (glitch) begin
            idle(6);
            bus.ps2_clk = 1'b0;
            idle(2);
            bus.ps2_clk = 1'b1;
            idle(BIT_HALF / 2 - 9);
        end else begin
            idle(BIT_HALF / 2 - 1);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_at);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i], i == glitch_at);
        model_byte(b, !bad_par, last_fall);
    endtask

    task automatic check_events(input string tag);
        ev_t         g, e;
        int unsigned lat, ge, ee;
        n_cmp++;
        assert (got_q.size() === exp_q.size()) else begin
            n_err++;
            $error("FAIL %s strobe count: got %0d expected %0d", tag, got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            assert ({g.code, g.brk, g.ext, g.keys} === {e.code, e.brk, e.ext, e.keys}) else begin
                n_err++;
                $error("FAIL %s code/brk/ext/keys: got %h/%b/%b/%b expected %h/%b/%b/%b",
                       tag, g.code, g.brk, g.ext, g.keys, e.code, e.brk, e.ext, e.keys);
            end
            lat = g.t - e.t;
            n_cmp++;
            assert ((lat >= LAT_MIN && lat <= LAT_MAX) === 1'b1) else begin
                n_err++;
                $error("FAIL %s strobe latency: got %0d expected %0d..%0d", tag, lat, LAT_MIN, LAT_MAX);
            end
        end
        n_cmp++;
        assert (gerr_q.size() === eerr_q.size()) else begin
            n_err++;
            $error("FAIL %s frame_err count: got %0d expected %0d", tag, gerr_q.size(), eerr_q.size());
        end
        while (gerr_q.size() > 0 && eerr_q.size() > 0) begin
            ge  = gerr_q.pop_front();
            ee  = eerr_q.pop_front();
            lat = ge - ee;
            n_cmp++;
            assert ((lat >= LAT_MIN && lat <= LAT_MAX) === 1'b1) else begin
                n_err++;
                $error("FAIL %s frame_err latency: got %0d expected %0d..%0d", tag, lat, LAT_MIN, LAT_MAX);
            end
        end
        got_q.delete(); exp_q.delete(); gerr_q.delete(); eerr_q.delete();
        n_cmp++;
        assert (bus.keys === m_keys) else begin
            n_err++;
            $error("FAIL %s keys: got %b expected %b", tag, bus.keys, m_keys);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        assert ({bus.scan_code, bus.scan_valid, bus.scan_break, bus.scan_ext,
                 bus.frame_err, bus.keys} === 16'h0000) else begin
            n_err++;
            $error("FAIL %s outputs: got %h/%b/%b/%b/%b/%b expected all zero", tag, bus.scan_code,
                   bus.scan_valid, bus.scan_break, bus.scan_ext, bus.frame_err, bus.keys);
        end
    endtask

    initial begin
        logic [7:0] b;
        int         r;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        m_ext = 1'b0; m_brk = 1'b0; m_keys = 4'b0000;
        idle(5);
        check_reset_outputs("reset");
        reset = 1'b0;
        idle(10);

        send_frame(8'h1C, 1'b0, -1);
        idle(60);
        check_events("plain_1C");

        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'h74, 1'b0, -1);
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'hF0, 1'b0, -1);
        send_frame(8'h74, 1'b0, -1);
        idle(60);
        check_events("right_make_break");

        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'h6B, 1'b1, -1);
        send_frame(8'h6B, 1'b0, -1);
        idle(60);
        check_events("parity_err");

        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
        model_byte(8'h00, 1'b0, last_fall + TIMEOUT_CYCLES);
        idle(TIMEOUT_CYCLES + 60);
        send_frame(8'h1C, 1'b0, -1);
        idle(60);
        check_events("timeout");

        bus.ps2_clk = 1'b0;
        idle(2);
        bus.ps2_clk = 1'b1;
        idle(30);
        send_frame(8'h5A, 1'b0, 2);
        send_frame(8'h29, 1'b0, 9);
        idle(60);
        check_events("glitch");

        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
        @(negedge clk);
        bus.ps2_data = 1'b1;
        idle(BIT_HALF / 2);
        bus.ps2_clk = 1'b0;
        idle(4);
        reset = 1'b1;
        idle(3);
        check_reset_outputs("reset_midframe");
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        idle(10);
        reset = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0; m_keys = 4'b0000;
        idle(20);
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'h75, 1'b0, -1);
        idle(60);
        check_events("after_reset");

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 2)      b = 8'hE0;
            else if (r == 3) b = 8'hF0;
            else if (r <= 6) begin
                case ($urandom_range(0, 3))
                    0:       b = 8'h6B;
                    1:       b = 8'h74;
                    2:       b = 8'h75;
                    default: b = 8'h72;
                endcase
            end else         b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 9) == 0, -1);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 30)));
        end
        idle(60);
        check_events("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
